// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: carries a control field and a payload between two
// stages with a valid/ready handshake. SKID=0 gives a single entry with a
// combinational in_ready; SKID=1 adds a second (skid) entry so that in_ready
// depends only on registered state. Flush turns the held entries into bubbles,
// and a saturating counter records cycles where the output is backpressured.
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt,
    input  logic              stat_clr
);

    // Encoding doubles as the entry count so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic accept;
    logic dequeue;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = (state_q != ST_TWO) && !flush;
        end else begin : g_comb_ready
            assign in_ready = (!out_valid || out_ready) && !flush;
        end
    endgenerate

    assign accept  = in_valid && in_ready;
    assign dequeue = out_valid && out_ready;

    // Next entry state and contents; flush overrides any accept or dequeue.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && dequeue) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (dequeue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (dequeue) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating backpressure counter; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State and entry registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one SKID=0 and one SKID=1 instance share the
// same inputs; each is compared every cycle against a queue model of the
// stage, plus directed scenarios with hand-computed expectations.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              stat_clr;

    logic              in_ready_w  [2];
    logic              out_valid_w [2];
    logic [CTRL_W-1:0] out_ctrl_w  [2];
    logic [DATA_W-1:0] out_data_w  [2];
    logic [1:0]        occ_w       [2];
    logic [15:0]       stall_w     [2];

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             m_ent   [2][2];
    int                m_cnt   [2];
    logic [DATA_W-1:0] m_held  [2];
    logic [15:0]       m_stall [2];

    int checks = 0;
    int errors = 0;

    logic [CTRL_W-1:0] dlog[$];
    logic [DATA_W-1:0] d_a, d_b, d_c, d_x;

    // Free-running clock.
    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[0]), .out_data(out_data_w[0]),
        .occupancy(occ_w[0]), .stall_cnt(stall_w[0]), .stat_clr(stat_clr)
    );

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[1]), .out_data(out_data_w[1]),
        .occupancy(occ_w[1]), .stall_cnt(stall_w[1]), .stat_clr(stat_clr)
    );

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic model_ready(int d);
        if (flush) return 1'b0;
        if (d == 1) return (m_cnt[d] < 2);
        return (m_cnt[d] == 0) || out_ready;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]    = 0;
            m_held[d]   = '0;
            m_stall[d]  = '0;
            m_ent[d][0] = '0;
            m_ent[d][1] = '0;
        end
    endtask

    task automatic modelStep();
        beat_t nb;
        logic  acc;
        logic  deq;
        nb.ctrl = in_ctrl;
        nb.data = in_data;
        for (int d = 0; d < 2; d++) begin
            acc = in_valid && model_ready(d);
            deq = (m_cnt[d] > 0) && out_ready;
            if (stat_clr) m_stall[d] = '0;
            else if ((m_cnt[d] > 0) && !out_ready && (m_stall[d] != 16'hFFFF)) m_stall[d]++;
            if (flush) begin
                m_cnt[d] = 0;
            end else begin
                if (deq) begin
                    m_ent[d][0] = m_ent[d][1];
                    m_cnt[d]--;
                end
                if (acc) begin
                    m_ent[d][m_cnt[d]] = nb;
                    m_cnt[d]++;
                end
            end
            if (m_cnt[d] > 0) m_held[d] = m_ent[d][0].data;
        end
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d.out_valid", d), 128'(out_valid_w[d]), 128'(m_cnt[d] > 0));
            chk($sformatf("dut%0d.out_ctrl", d), 128'(out_ctrl_w[d]),
                (m_cnt[d] > 0) ? 128'(m_ent[d][0].ctrl) : 128'd0);
            chk($sformatf("dut%0d.out_data", d), 128'(out_data_w[d]),
                (m_cnt[d] > 0) ? 128'(m_ent[d][0].data) : 128'(m_held[d]));
            chk($sformatf("dut%0d.occupancy", d), 128'(occ_w[d]), 128'(m_cnt[d]));
            chk($sformatf("dut%0d.stall_cnt", d), 128'(stall_w[d]), 128'(m_stall[d]));
            chk($sformatf("dut%0d.in_ready", d), 128'(in_ready_w[d]), 128'(model_ready(d)));
        end
    endtask

    task automatic drive(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                         input logic ordy, input logic fl, input logic sc);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        stat_clr  = sc;
    endtask

    task automatic step();
        #2;
        checkOutput();
        if (out_valid_w[1] && out_ready) dlog.push_back(out_ctrl_w[1]);
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                                 input logic ordy, input logic fl, input logic sc);
        drive(iv, ic, id, ordy, fl, sc);
        step();
    endtask

    task automatic pulseReset();
        rst_n = 1'b1;
        #1;
        modelReset();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst dut%0d.out_valid", d), 128'(out_valid_w[d]), 128'd0);
            chk($sformatf("rst dut%0d.out_ctrl", d), 128'(out_ctrl_w[d]), 128'd0);
            chk($sformatf("rst dut%0d.out_data", d), 128'(out_data_w[d]), 128'd0);
            chk($sformatf("rst dut%0d.occupancy", d), 128'(occ_w[d]), 128'd0);
            chk($sformatf("rst dut%0d.stall_cnt", d), 128'(stall_w[d]), 128'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst dut0.in_ready", 128'(in_ready_w[0]), 128'd1);
        chk("rst dut1.in_ready", 128'(in_ready_w[1]), 128'd1);
        step();
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        pulseReset();

        $display("[TB] streaming");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), rand128(), 1'b1, 1'b0, 1'b0);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("stream dut%0d.out_ctrl", d), 128'(out_ctrl_w[d]), 128'(i));
                chk($sformatf("stream dut%0d.occupancy", d), 128'(occ_w[d]), 128'd1);
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain dut1.out_valid", 128'(out_valid_w[1]), 128'd0);
        chk("drain dut1.out_ctrl", 128'(out_ctrl_w[1]), 128'd0);

        $display("[TB] backpressure");
        pulseReset();
        dlog.delete();
        d_a = rand128(); d_b = rand128(); d_c = rand128();
        applyStimulus(1'b1, 8'hA1, d_a, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, d_b, 1'b0, 1'b0, 1'b0);
        chk("bp dut1.occupancy", 128'(occ_w[1]), 128'd2);
        chk("bp dut1.out_ctrl", 128'(out_ctrl_w[1]), 128'hA1);
        drive(1'b1, 8'hC3, d_c, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp dut1.in_ready", 128'(in_ready_w[1]), 128'd0);
        step();
        step();
        chk("bp dut1.stall_cnt", 128'(stall_w[1]), 128'd3);
        chk("bp dut1.out_data", 128'(out_data_w[1]), 128'(d_a));
        applyStimulus(1'b1, 8'hC3, d_c, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC3, d_c, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp delivered count", 128'(dlog.size()), 128'd3);
        if (dlog.size() == 3) begin
            chk("bp order 0", 128'(dlog[0]), 128'hA1);
            chk("bp order 1", 128'(dlog[1]), 128'hB2);
            chk("bp order 2", 128'(dlog[2]), 128'hC3);
        end

        $display("[TB] flush");
        pulseReset();
        d_a = rand128();
        applyStimulus(1'b1, 8'h11, d_a, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, rand128(), 1'b0, 1'b0, 1'b0);
        chk("fl dut1.occupancy", 128'(occ_w[1]), 128'd2);
        drive(1'b1, 8'hEE, rand128(), 1'b0, 1'b1, 1'b0);
        #1;
        chk("fl dut0.in_ready", 128'(in_ready_w[0]), 128'd0);
        chk("fl dut1.in_ready", 128'(in_ready_w[1]), 128'd0);
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("fl dut%0d.out_valid", d), 128'(out_valid_w[d]), 128'd0);
            chk($sformatf("fl dut%0d.out_ctrl", d), 128'(out_ctrl_w[d]), 128'd0);
            chk($sformatf("fl dut%0d.occupancy", d), 128'(occ_w[d]), 128'd0);
            chk($sformatf("fl dut%0d.out_data", d), 128'(out_data_w[d]), 128'(d_a));
        end
        dlog.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("fl beat absent", 128'(dlog.size()), 128'd0);

        $display("[TB] single entry");
        pulseReset();
        applyStimulus(1'b1, 8'h31, rand128(), 1'b0, 1'b0, 1'b0);
        d_x = rand128();
        drive(1'b1, 8'h32, d_x, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0 dut0.in_ready high", 128'(in_ready_w[0]), 128'd1);
        step();
        chk("s0 dut0.out_valid", 128'(out_valid_w[0]), 128'd1);
        chk("s0 dut0.out_ctrl", 128'(out_ctrl_w[0]), 128'h32);
        chk("s0 dut0.out_data", 128'(out_data_w[0]), 128'(d_x));
        chk("s0 dut0.occupancy", 128'(occ_w[0]), 128'd1);
        drive(1'b1, 8'h33, rand128(), 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0 dut0.in_ready ready", 128'(in_ready_w[0]), 128'd1);
        out_ready = 1'b0;
        #1;
        chk("s0 dut0.in_ready fall", 128'(in_ready_w[0]), 128'd0);
        step();
        chk("s0 dut0.out_ctrl hold", 128'(out_ctrl_w[0]), 128'h32);

        $display("[TB] random traffic");
        pulseReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), rand128(),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 2);
        end

        $display("[TB] stall saturation");
        pulseReset();
        applyStimulus(1'b1, 8'h55, rand128(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat dut0.stall_cnt", 128'(stall_w[0]), 128'hFFFF);
        chk("sat dut1.stall_cnt", 128'(stall_w[1]), 128'hFFFF);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr dut1.stall_cnt", 128'(stall_w[1]), 128'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("resume dut1.stall_cnt", 128'(stall_w[1]), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline stage register that replaces the fixed decode/execute latch design with one reusable block.
- Carries a control field and a data payload between two stages using a valid/ready handshake.
- Supports synchronous flush (bubble insertion) and an optional two-entry skid buffer so in_ready can be registered.
- Captures on the rising edge only; there is no half-cycle output retiming.

Parameters:
- DATA_W, 128, payload width in bits (operands, immediate, instruction, address, register indices).
- CTRL_W, 8, control width in bits (RegWrite, ALUSrc, Shift, ALUControl, ...). Forced to zero on bubbles.
- SKID, 1, 0 selects a single-entry stage with combinational in_ready; 1 selects a two-entry skid buffer with registered in_ready.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush: discard all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control of the head entry; 0 when out_valid=0.
- out_data  out  DATA_W  payload of the head entry; held when invalid.
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0).
- stall_cnt  out  16  saturating count of cycles with out_valid && !out_ready.
- stat_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (asynchronous, rst_n=1):
  - All valid bits 0; out_valid=0.
  - out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - Skid entry cleared.
  - in_ready=1 after reset for both SKID settings.
- Handshakes:
  - Transfer in: in_valid && in_ready at posedge.
  - Transfer out: out_valid && out_ready at posedge.
  - Latency from accepted input to out_valid: 1 cycle.
  - Output always comes from the main (head) entry, in strict FIFO order. No beat is ever dropped or duplicated except by flush.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational), forced 0 while flush=1.
  - Accept with simultaneous dequeue: the main entry is replaced and stays valid.
  - Dequeue without accept: main becomes invalid and out_ctrl goes to 0.
- SKID=1 state machine (EMPTY, ONE, TWO); in_ready = (state != TWO) && !flush.
  - EMPTY: accept -> ONE (main <= input).
  - ONE, accept and dequeue -> ONE (main <= input).
  - ONE, accept without dequeue -> TWO (skid <= input).
  - ONE, dequeue without accept -> EMPTY.
  - TWO, dequeue -> ONE (main <= skid, skid invalid). No accept is possible in TWO.
  - in_ready is taken from state only (registered); it has no combinational path from out_ready.
- Flush:
  - Highest priority, over any accept or dequeue in the same cycle.
  - Next cycle: all entries invalid, out_ctrl=0, occupancy=0; out_data holds its old value.
  - Any in_valid beat in the flush cycle is not accepted, because in_ready=0.
  - A dequeue coinciding with flush still counts as delivered downstream; the stage itself only clears.
- Bubble safety: out_ctrl is 0 whenever out_valid=0, including after reset, flush and drain.
- occupancy: equals the number of valid entries after each posedge.
- stall_cnt:
  - Increments each cycle out_valid && !out_ready; saturates at 16'hFFFF.
  - stat_clr has priority over increment and sets the count to 0.
  - Not affected by flush.
- Hold: data and control are stable while out_valid && !out_ready; out_data/out_ctrl change only on dequeue, accept into an empty head, or flush (ctrl only).

Test Plan:
- Reset mid-stream (SKID=1, occupancy=2, assert rst_n) -> immediately out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0; in_ready=1 after release.
- Streaming, out_ready=1 constantly, in_ctrl=8'h01..8'h10 on consecutive cycles -> identical sequence on out_ctrl, 1-cycle latency, no gaps, occupancy stays 1.
- Backpressure (SKID=1): out_ready=0, send A, B, C -> A held on output, B captured in skid, in_ready=0 from the cycle after B, C held upstream, occupancy=2, stall_cnt counts. Release -> A, B, C delivered in order.
- Flush with occupancy=2 and in_valid=1 in the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, incoming beat absent from the output stream.
- SKID=0 dequeue+accept same cycle, then out_ready=0 -> in_ready falls combinationally when out_ready falls; payload replaced without a bubble.
- stall_cnt: hold out_valid=1, out_ready=0 for 70000 cycles -> 16'hFFFF held; stat_clr pulse -> 0, then resumes counting.
